pix_palette_decoder: RTL and testbench
======================================

// Module: pix_palette_decoder
// PURPOSE
//  Streaming pixel decoder: maps PIX_W-bit encoded pixel codes to OUT_W-bit grey levels via a per-mode palette.
//  Parametrised successor of the fixed LOGO/Cubes combinational decode. Adds a valid/ready stream,
//  one registered output stage, runtime-writable palettes and line-length checking.
//  Sits between the frame memory read path and the pixel output formatter.
// PARAMETERS
//  PIX_W    2    encoded pixel width; palette depth = 2**PIX_W
//  OUT_W    8    decoded pixel width
//  SEL_W    3    mode select width; number of palettes = 2**SEL_W
//  LINE_LEN 640  pixels per line, used by the in_last length check
//  CNT_W    10   pixel counter width; must satisfy 2**CNT_W >= LINE_LEN
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous reset, active-high
//  in_valid     in   1      input pixel valid
//  in_ready     out  1      input accepted when in_valid && in_ready
//  in_pix       in   PIX_W  encoded pixel code
//  in_sel       in   SEL_W  palette/mode select, sampled together with in_pix
//  in_last      in   1      last pixel of the line
//  out_valid    out  1      decoded pixel valid
//  out_ready    in   1      downstream accepts
//  out_data     out  OUT_W  decoded pixel
//  out_last     out  1      in_last, delayed with the data
//  pix_cnt      out  CNT_W  pixels accepted in the current line
//  err_len      out  1      sticky line-length error; cleared only by rst
//  pal_wr_en    in   1      palette write strobe (PALETTE_WR_EN only)
//  pal_wr_sel   in   SEL_W  palette written
//  pal_wr_idx   in   PIX_W  entry written
//  pal_wr_data  in   OUT_W  entry value
// BEHAVIOUR
//  Reset (async assert, sync release): out_valid=0, out_data=0, out_last=0, pix_cnt=0, err_len=0.
//   Palettes reload their defaults.
//  Palette defaults (OUT_W=8):
//   sel 7 (LOGO):  {00,64,64,FF}
//   sel 6 (Cubes): {00,32,32,96}
//   all other entries 00.
//  For other widths: code 0 maps to 0, and nonzero codes take the defaults scaled by MSB alignment.
//  Handshake:
//   in_ready = !out_valid || out_ready; it is combinational from out_ready and never depends on in_valid.
//   On accept, the next cycle has out_valid=1, out_data=pal[in_sel][in_pix] and out_last=in_last. Latency is 1 cycle.
//   Accept and drain in the same cycle gives full throughput, 1 pixel per clk.
//   While out_valid && !out_ready, out_data and out_last hold stable.
//   out_valid falls only after a drain with no new accept.
//  Line counter:
//   pix_cnt increments on each accept and wraps to 0 on an accept with in_last=1.
//   err_len is set when in_last is accepted with pix_cnt != LINE_LEN-1.
//   err_len is also set when pix_cnt == LINE_LEN-1 is accepted without in_last; in that case pix_cnt still wraps to 0.
//  Palette write: one entry per cycle, visible to pixels accepted on the following cycle.
//   When a write and an accept happen in the same cycle, the accepted pixel uses the old entry.
//  in_sel may change on every pixel. There is no sel-specific decode beyond the table.
//  Reset asserted mid-line drops the in-flight pixel and all state, with no partial output.
// CONFIGURATION
//  PALETTE_WR_EN defined: the pal_wr_* ports exist and the table is a register array written as above.
//  PALETTE_WR_EN undefined: the pal_wr_* ports are absent and the table is constant defaults (pure ROM).
//   Behaviour is otherwise identical.
// STRUCTURE
//  Package pix_dec_pkg holds:
//   default palette constants (PAL_LOGO, PAL_CUBES);
//   SEL_LOGO=3'b111 and SEL_CUBES=3'b110;
//   the palette entry typedef.
//  Sub-module pix_palette_table holds the table: read port (sel, idx) -> data, reset-to-default,
//   and a write port under PALETTE_WR_EN.
//  The top holds the output register, handshake and line counter.
// TESTING
//  1. Reset, out_ready=1, stream sel=7 codes 0,1,2,3 -> out_data 00,64,64,FF, one per cycle, 1-cycle latency.
//  2. sel=6 codes 3,1,0 with out_ready low 3 cycles on the 2nd pixel
//     -> 96 held stable then 32,00; in_ready low while stalled; no loss or duplication.
//  3. sel=2 any code -> 00. Then write pal[2][3]=AA together with an accept of code 3 -> 00;
//     the next code 3 -> AA.
//  4. LINE_LEN=4: last on the 4th pixel -> pix_cnt 0, err_len 0, out_last on the 4th output.
//     Last on the 3rd pixel -> err_len=1 and it stays set.
//  5. rst pulse mid-line with out_valid=1 -> out_valid and pix_cnt 0 immediately (async);
//     palette written in test 3 returns to 00.
//  6. Random valid/ready for 10k pixels vs reference model -> exact match; run both with and without PALETTE_WR_EN.

Source files
------------

// File: rtl/pix_dec_pkg.sv
// Shared types and default palettes for the pixel palette decoder.
// Defaults are stored 8 bits wide; pal_default() rescales them to any output width.
package pix_dec_pkg;

   localparam logic [2:0] SEL_LOGO  = 3'b111;
   localparam logic [2:0] SEL_CUBES = 3'b110;

   typedef logic [7:0] pal_entry_t;

   localparam pal_entry_t PAL_LOGO  [4] = '{8'h00, 8'h64, 8'h64, 8'hFF};
   localparam pal_entry_t PAL_CUBES [4] = '{8'h00, 8'h32, 8'h32, 8'h96};

   // MSB-aligned default entry: wider outputs shift left, narrower outputs keep the top bits.
   function automatic logic [31:0] pal_default(input int sel, input int idx, input int out_w);
      logic [31:0] v;
      v = 32'd0;
      if (idx < 4) begin
         if (sel == int'(SEL_LOGO))
            v = 32'(PAL_LOGO[idx[1:0]]);
         else if (sel == int'(SEL_CUBES))
            v = 32'(PAL_CUBES[idx[1:0]]);
      end
      if (out_w >= 8)
         return v << (out_w - 8);
      return v >> (8 - out_w);
   endfunction

endpackage

// File: rtl/pix_palette_table.sv
// Palette table: combinational read of (sel, idx); reloads defaults on reset.
// Latency: 0 cycles on read; writes (PALETTE_WR_EN) become visible the cycle after the strobe.
// Backpressure: none, one write per cycle is always accepted.
module pix_palette_table
   import pix_dec_pkg::*;
#(
   parameter int PIX_W = 2,
   parameter int OUT_W = 8,
   parameter int SEL_W = 3
) (
`ifdef PALETTE_WR_EN
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [SEL_W-1:0] wr_sel,
   input  logic [PIX_W-1:0] wr_idx,
   input  logic [OUT_W-1:0] wr_data,
`endif
   input  logic [SEL_W-1:0] rd_sel,
   input  logic [PIX_W-1:0] rd_idx,
   output logic [OUT_W-1:0] rd_data
);

   localparam int N_SEL = 2**SEL_W;
   localparam int N_IDX = 2**PIX_W;

`ifdef PALETTE_WR_EN
   logic [OUT_W-1:0] tbl_q [N_SEL][N_IDX];
   logic [OUT_W-1:0] tbl_d [N_SEL][N_IDX];

   always_comb begin
      tbl_d = tbl_q;
      if (wr_en)
         tbl_d[wr_sel][wr_idx] = wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < N_SEL; s++)
            for (int i = 0; i < N_IDX; i++)
               tbl_q[s][i] <= OUT_W'(pal_default(s, i, OUT_W));
      end else begin
         tbl_q <= tbl_d;
      end
   end

   // Reads see the registered table, so a same-cycle write does not affect the read.
   assign rd_data = tbl_q[rd_sel][rd_idx];
`else
   logic [OUT_W-1:0] rom [N_SEL][N_IDX];

   for (genvar s = 0; s < N_SEL; s++) begin : g_sel
      for (genvar i = 0; i < N_IDX; i++) begin : g_idx
         assign rom[s][i] = OUT_W'(pal_default(s, i, OUT_W));
      end
   end

   assign rd_data = rom[rd_sel][rd_idx];
`endif

endmodule

// File: rtl/pix_palette_decoder.sv
// Streaming palette decoder with line-length check; PALETTE_WR_EN adds runtime palette writes.
// Latency: 1 cycle, sustains 1 pixel/clk when accept and drain coincide.
// Backpressure: in_ready = !out_valid || out_ready; output register holds while stalled.
module pix_palette_decoder
   import pix_dec_pkg::*;
#(
   parameter int PIX_W    = 2,
   parameter int OUT_W    = 8,
   parameter int SEL_W    = 3,
   parameter int LINE_LEN = 640,
   parameter int CNT_W    = 10
) (
   input  logic             clk,
   input  logic             rst,
`ifdef PALETTE_WR_EN
   input  logic             pal_wr_en,
   input  logic [SEL_W-1:0] pal_wr_sel,
   input  logic [PIX_W-1:0] pal_wr_idx,
   input  logic [OUT_W-1:0] pal_wr_data,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] in_pix,
   input  logic [SEL_W-1:0] in_sel,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_last,
   output logic [CNT_W-1:0] pix_cnt,
   output logic             err_len
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_LEN - 1);

   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] out_data_q,  out_data_d;
   logic             out_last_q,  out_last_d;
   logic [CNT_W-1:0] pix_cnt_q,   pix_cnt_d;
   logic             err_len_q,   err_len_d;
   logic [OUT_W-1:0] pal_rd_data;
   logic             accept;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   pix_palette_table #(
      .PIX_W (PIX_W),
      .OUT_W (OUT_W),
      .SEL_W (SEL_W)
   ) u_table (
`ifdef PALETTE_WR_EN
      .clk     (clk),
      .rst     (rst),
      .wr_en   (pal_wr_en),
      .wr_sel  (pal_wr_sel),
      .wr_idx  (pal_wr_idx),
      .wr_data (pal_wr_data),
`endif
      .rd_sel  (in_sel),
      .rd_idx  (in_pix),
      .rd_data (pal_rd_data)
   );

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      pix_cnt_d   = pix_cnt_q;
      err_len_d   = err_len_q;

      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = pal_rd_data;
         out_last_d  = in_last;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      // A line ends either on in_last or on reaching LINE_LEN; any disagreement is a length error.
      if (accept) begin
         if (in_last) begin
            pix_cnt_d = '0;
            if (pix_cnt_q != CNT_LAST)
               err_len_d = 1'b1;
         end else if (pix_cnt_q == CNT_LAST) begin
            pix_cnt_d = '0;
            err_len_d = 1'b1;
         end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         pix_cnt_q   <= '0;
         err_len_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         pix_cnt_q   <= pix_cnt_d;
         err_len_q   <= err_len_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign pix_cnt   = pix_cnt_q;
   assign err_len   = err_len_q;

endmodule

// File: tb/tb_pix_palette_decoder.sv
// Directed and random checks of pix_palette_decoder with LINE_LEN=4; PALETTE_WR_EN selects the writable-table build.
module tb_pix_palette_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_pix;
   logic [2:0] in_sel;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;
   logic [2:0] pix_cnt;
   logic       err_len;
`ifdef PALETTE_WR_EN
   logic       pal_wr_en;
   logic [2:0] pal_wr_sel;
   logic [1:0] pal_wr_idx;
   logic [7:0] pal_wr_data;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pix_palette_decoder #(
      .PIX_W    (2),
      .OUT_W    (8),
      .SEL_W    (3),
      .LINE_LEN (4),
      .CNT_W    (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
`ifdef PALETTE_WR_EN
      .pal_wr_en   (pal_wr_en),
      .pal_wr_sel  (pal_wr_sel),
      .pal_wr_idx  (pal_wr_idx),
      .pal_wr_data (pal_wr_data),
`endif
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_pix      (in_pix),
      .in_sel      (in_sel),
      .in_last     (in_last),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .pix_cnt     (pix_cnt),
      .err_len     (err_len)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic v, input logic [2:0] s, input logic [1:0] p, input logic l);
      in_valid = v;
      in_sel   = s;
      in_pix   = p;
      in_last  = l;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                          input logic l, input logic [2:0] c, input logic e);
      chk({tag, "_valid"}, 32'(out_valid), 32'(v));
      chk({tag, "_data"},  32'(out_data),  32'(d));
      chk({tag, "_last"},  32'(out_last),  32'(l));
      chk({tag, "_cnt"},   32'(pix_cnt),   32'(c));
      chk({tag, "_err"},   32'(err_len),   32'(e));
   endtask

   logic [7:0] pal_m [8][4];
   logic [8:0] exp_q [$];

   task automatic model_reset();
      for (int s = 0; s < 8; s++)
         for (int i = 0; i < 4; i++)
            pal_m[s][i] = 8'h00;
      pal_m[7][1] = 8'h64; pal_m[7][2] = 8'h64; pal_m[7][3] = 8'hFF;
      pal_m[6][1] = 8'h32; pal_m[6][2] = 8'h32; pal_m[6][3] = 8'h96;
      exp_q.delete();
   endtask

   initial begin
      logic [2:0] m_cnt;
      logic       m_err;
      logic       exp_rdy;
      logic [8:0] head;
      int         pixels;
      int         cycles;

      rst = 1'b1;
      out_ready = 1'b1;
      drv(1'b0, 3'd0, 2'd0, 1'b0);
`ifdef PALETTE_WR_EN
      pal_wr_en = 1'b0; pal_wr_sel = 3'd0; pal_wr_idx = 2'd0; pal_wr_data = 8'h00;
`endif
      repeat (2) tick();
      chk_out("reset", 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
      rst = 1'b0;
      #1;
      chk("reset_in_ready", 32'(in_ready), 32'd1);

      // Test 1: LOGO stream, last on the 4th pixel of a 4-pixel line.
      drv(1'b1, 3'd7, 2'd0, 1'b0); tick(); chk_out("t1_p0", 1'b1, 8'h00, 1'b0, 3'd1, 1'b0);
      drv(1'b1, 3'd7, 2'd1, 1'b0); tick(); chk_out("t1_p1", 1'b1, 8'h64, 1'b0, 3'd2, 1'b0);
      drv(1'b1, 3'd7, 2'd2, 1'b0); tick(); chk_out("t1_p2", 1'b1, 8'h64, 1'b0, 3'd3, 1'b0);
      drv(1'b1, 3'd7, 2'd3, 1'b1); tick(); chk_out("t1_p3", 1'b1, 8'hFF, 1'b1, 3'd0, 1'b0);
      drv(1'b0, 3'd7, 2'd0, 1'b0); tick(); chk("t1_drain_valid", 32'(out_valid), 32'd0);

      // Test 2: Cubes with a 3-cycle downstream stall while the 2nd pixel waits.
      drv(1'b1, 3'd6, 2'd3, 1'b0); tick(); chk_out("t2_p0", 1'b1, 8'h96, 1'b0, 3'd1, 1'b0);
      drv(1'b1, 3'd6, 2'd1, 1'b0);
      out_ready = 1'b0;
      #1;
      chk("t2_stall_rdy", 32'(in_ready), 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_out("t2_hold", 1'b1, 8'h96, 1'b0, 3'd1, 1'b0);
         chk("t2_hold_rdy", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("t2_release_rdy", 32'(in_ready), 32'd1);
      tick(); chk_out("t2_p1", 1'b1, 8'h32, 1'b0, 3'd2, 1'b0);
      drv(1'b1, 3'd6, 2'd0, 1'b0); tick(); chk_out("t2_p2", 1'b1, 8'h00, 1'b0, 3'd3, 1'b0);
      drv(1'b0, 3'd6, 2'd0, 1'b0); tick(); chk("t2_drain_valid", 32'(out_valid), 32'd0);

      // Test 3: unmapped mode, then a palette write racing an accept.
      drv(1'b1, 3'd2, 2'd1, 1'b1); tick(); chk_out("t3_p0", 1'b1, 8'h00, 1'b1, 3'd0, 1'b0);
`ifdef PALETTE_WR_EN
      pal_wr_en = 1'b1; pal_wr_sel = 3'd2; pal_wr_idx = 2'd3; pal_wr_data = 8'hAA;
`endif
      drv(1'b1, 3'd2, 2'd3, 1'b0); tick(); chk_out("t3_same_cyc", 1'b1, 8'h00, 1'b0, 3'd1, 1'b0);
`ifdef PALETTE_WR_EN
      pal_wr_en = 1'b0;
      drv(1'b1, 3'd2, 2'd3, 1'b0); tick(); chk_out("t3_next", 1'b1, 8'hAA, 1'b0, 3'd2, 1'b0);
`else
      drv(1'b1, 3'd2, 2'd3, 1'b0); tick(); chk_out("t3_next", 1'b1, 8'h00, 1'b0, 3'd2, 1'b0);
`endif
      drv(1'b1, 3'd2, 2'd0, 1'b0); tick(); chk_out("t3_p3", 1'b1, 8'h00, 1'b0, 3'd3, 1'b0);
      drv(1'b1, 3'd7, 2'd3, 1'b1); tick(); chk_out("t3_p4", 1'b1, 8'hFF, 1'b1, 3'd0, 1'b0);
      drv(1'b0, 3'd7, 2'd0, 1'b0); tick();

      // Test 4: last arriving on the 3rd pixel flags a sticky length error.
      drv(1'b1, 3'd7, 2'd1, 1'b0); tick(); chk_out("t4_p0", 1'b1, 8'h64, 1'b0, 3'd1, 1'b0);
      drv(1'b1, 3'd7, 2'd2, 1'b0); tick(); chk_out("t4_p1", 1'b1, 8'h64, 1'b0, 3'd2, 1'b0);
      drv(1'b1, 3'd7, 2'd3, 1'b1); tick(); chk_out("t4_short", 1'b1, 8'hFF, 1'b1, 3'd0, 1'b1);
      drv(1'b1, 3'd6, 2'd2, 1'b0); tick(); chk_out("t4_sticky", 1'b1, 8'h32, 1'b0, 3'd1, 1'b1);

      // Test 5: async reset with a pixel in flight.
      out_ready = 1'b0;
      tick(); chk_out("t5_pre", 1'b1, 8'h32, 1'b0, 3'd1, 1'b1);
      rst = 1'b1;
      #1;
      chk_out("t5_async", 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
      drv(1'b0, 3'd0, 2'd0, 1'b0);
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      drv(1'b1, 3'd2, 2'd3, 1'b0); tick(); chk_out("t5_pal_default", 1'b1, 8'h00, 1'b0, 3'd1, 1'b0);

      // Reaching LINE_LEN without in_last also flags an error and wraps the counter.
      drv(1'b1, 3'd0, 2'd3, 1'b0); tick(); chk("t5_cnt2", 32'(pix_cnt), 32'd2);
      tick(); chk("t5_cnt3", 32'(pix_cnt), 32'd3);
      tick(); chk_out("t5_overlen", 1'b1, 8'h00, 1'b0, 3'd0, 1'b1);
      drv(1'b0, 3'd0, 2'd0, 1'b0); tick();

      // Test 6: random traffic against a scoreboard and counter model.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      m_cnt  = 3'd0;
      m_err  = 1'b0;
      pixels = 0;
      cycles = 0;
      while (pixels < 10000 && cycles < 60000) begin
         drv(($urandom % 5) != 0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
             ($urandom % 4) == 0);
         out_ready = ($urandom % 5) != 0;
`ifdef PALETTE_WR_EN
         pal_wr_en   = ($urandom % 8) == 0;
         pal_wr_sel  = 3'($urandom_range(0, 7));
         pal_wr_idx  = 2'($urandom_range(0, 3));
         pal_wr_data = 8'($urandom);
`endif
         #1;
         exp_rdy = (exp_q.size() == 0) || out_ready;
         chk("r_in_ready", 32'(in_ready), 32'(exp_rdy));
         chk("r_out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            head = exp_q[0];
            chk("r_out_data", 32'(out_data), 32'(head[7:0]));
            chk("r_out_last", 32'(out_last), 32'(head[8]));
         end
         chk("r_pix_cnt", 32'(pix_cnt), 32'(m_cnt));
         chk("r_err_len", 32'(err_len), 32'(m_err));

         if (exp_q.size() != 0 && out_ready)
            void'(exp_q.pop_front());
         if (in_valid && exp_rdy) begin
            exp_q.push_back({in_last, pal_m[in_sel][in_pix]});
            if (in_last) begin
               if (m_cnt != 3'd3) m_err = 1'b1;
               m_cnt = 3'd0;
            end else if (m_cnt == 3'd3) begin
               m_err = 1'b1;
               m_cnt = 3'd0;
            end else begin
               m_cnt = m_cnt + 3'd1;
            end
            pixels++;
         end
`ifdef PALETTE_WR_EN
         if (pal_wr_en)
            pal_m[pal_wr_sel][pal_wr_idx] = pal_wr_data;
`endif
         cycles++;
         tick();
      end
      chk("r_pixels_done", 32'(pixels), 32'd10000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
